mac_rx_frame: RTL and testbench



---
 rtl/mac_rx_frame_if.sv | 26 ++
 rtl/mac_rx_frame.sv | 183 ++++++++++++++++++
 tb/tb_mac_rx_frame.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rx_frame_if.sv
// GMII receive, RX FIFO write and frame-ready handshake signals of the MAC RX framer.
// The master side drives GMII and fd; the slave side is the framer itself.
interface mac_rx_frame_if;
  logic        gmii_rxdv;
  logic [7:0]  gmii_rxd;
  logic        gmii_rxer;
  logic [7:0]  fifo_txd;
  logic        fifo_txen;
  logic        fifo_clr;
  logic [11:0] FIFO_NUM;
  logic        fs;
  logic        fd;
  logic        err;
  logic [15:0] drop_cnt;
  logic [2:0]  state_fm;

  modport master (
    output gmii_rxdv, gmii_rxd, gmii_rxer, fd,
    input  fifo_txd, fifo_txen, fifo_clr, FIFO_NUM, fs, err, drop_cnt, state_fm
  );

  modport slave (
    input  gmii_rxdv, gmii_rxd, gmii_rxer, fd,
    output fifo_txd, fifo_txen, fifo_clr, FIFO_NUM, fs, err, drop_cnt, state_fm
  );
endinterface

// File: rtl/mac_rx_frame.sv
// GMII receive framer: strips preamble/SFD, filters DA, checks length and FCS,
// streams payload (FCS excluded) into the RX FIFO and hands good frames downstream.
module mac_rx_frame #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
  parameter logic [2:0]  PRE_MIN   = 3'd6,
  parameter logic [11:0] MIN_LEN   = 12'd64,
  parameter logic [11:0] MAX_LEN   = 12'd1518
) (
  input  logic          clk,
  input  logic          rst,
  mac_rx_frame_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREAM = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    READY = 3'd4,
    FLUSH = 3'd5,
    SKIP  = 3'd6
  } state_e;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  state_e      state_q;
  logic [2:0]  pre_cnt_q;
  logic [11:0] byte_cnt_q;
  logic [31:0] crc_q;
  logic [31:0] dly_q;
  logic        uc_ok_q, bc_ok_q, rx_bad_q, len_bad_q;
  logic        rxdv_q;
  logic [7:0]  fifo_txd_q;
  logic        fifo_txen_q, fifo_clr_q, fs_q, err_q;
  logic [11:0] fifo_num_q;
  logic [15:0] drop_cnt_q;

  logic [31:0] crc_d;
  logic [11:0] byte_cnt_d;
  logic [15:0] drop_cnt_d;
  logic        len_over;
  logic [7:0]  mac_byte;
  logic        frame_good;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d      = crc_byte(crc_q, bus.gmii_rxd);
    byte_cnt_d = (byte_cnt_q == 12'hFFF) ? byte_cnt_q : byte_cnt_q + 12'd1;
    drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
    len_over   = byte_cnt_d > MAX_LEN;
    frame_good = (uc_ok_q | bc_ok_q) & !rx_bad_q & !len_bad_q &
                 (byte_cnt_q >= MIN_LEN) & (crc_q == CRC_RESIDUE);
    case (byte_cnt_q[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      3'd5:    mac_byte = LOCAL_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees the
  // pre-edge values; the pulse outputs default low and are re-asserted by the branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pre_cnt_q   <= 3'd0;
      byte_cnt_q  <= 12'd0;
      crc_q       <= 32'hFFFFFFFF;
      dly_q       <= 32'd0;
      uc_ok_q     <= 1'b0;
      bc_ok_q     <= 1'b0;
      rx_bad_q    <= 1'b0;
      len_bad_q   <= 1'b0;
      rxdv_q      <= 1'b0;
      fifo_txd_q  <= 8'd0;
      fifo_txen_q <= 1'b0;
      fifo_clr_q  <= 1'b0;
      fs_q        <= 1'b0;
      err_q       <= 1'b0;
      fifo_num_q  <= 12'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      rxdv_q      <= bus.gmii_rxdv;
      fifo_txen_q <= 1'b0;
      fifo_clr_q  <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.gmii_rxdv) begin
            if (bus.gmii_rxd == 8'h55) begin
              state_q   <= PREAM;
              pre_cnt_q <= 3'd1;
            end else begin
              state_q <= SKIP;
            end
          end
        end
        PREAM: begin
          if (!bus.gmii_rxdv) begin
            state_q <= IDLE;
          end else if (bus.gmii_rxd == 8'h55) begin
            if (pre_cnt_q != 3'd7) pre_cnt_q <= pre_cnt_q + 3'd1;
          end else if (bus.gmii_rxd == 8'hD5 && pre_cnt_q >= PRE_MIN) begin
            state_q    <= DATA;
            crc_q      <= 32'hFFFFFFFF;
            byte_cnt_q <= 12'd0;
            dly_q      <= 32'd0;
            uc_ok_q    <= 1'b1;
            bc_ok_q    <= 1'b1;
            rx_bad_q   <= 1'b0;
            len_bad_q  <= 1'b0;
          end else begin
            state_q <= SKIP;
          end
        end
        DATA: begin
          if (!bus.gmii_rxdv) begin
            state_q <= CHECK;
          end else begin
            dly_q      <= {dly_q[23:0], bus.gmii_rxd};
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            if (byte_cnt_q < 12'd6) begin
              if (bus.gmii_rxd != mac_byte) uc_ok_q <= 1'b0;
              if (bus.gmii_rxd != 8'hFF)    bc_ok_q <= 1'b0;
            end
            if (bus.gmii_rxer) rx_bad_q <= 1'b1;
            // The 4-byte delay keeps the trailing FCS out of the FIFO.
            if (len_over) begin
              len_bad_q <= 1'b1;
            end else if (!len_bad_q && byte_cnt_q >= 12'd4) begin
              fifo_txd_q  <= dly_q[31:24];
              fifo_txen_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (frame_good) begin
            state_q    <= READY;
            fs_q       <= 1'b1;
            fifo_num_q <= byte_cnt_q - 12'd4;
          end else begin
            state_q    <= FLUSH;
            fifo_clr_q <= 1'b1;
            err_q      <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
          end
        end
        READY: begin
          if (bus.gmii_rxdv && !rxdv_q) drop_cnt_q <= drop_cnt_d;
          if (bus.fd)     fs_q    <= 1'b0;
          else if (!fs_q) state_q <= IDLE;
        end
        FLUSH: state_q <= IDLE;
        SKIP: begin
          if (!bus.gmii_rxdv) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_txd  = fifo_txd_q;
  assign bus.fifo_txen = fifo_txen_q;
  assign bus.fifo_clr  = fifo_clr_q;
  assign bus.FIFO_NUM  = fifo_num_q;
  assign bus.fs        = fs_q;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.state_fm  = state_q;

endmodule

// File: tb/tb_mac_rx_frame.sv
// Self-checking bench for mac_rx_frame: table of frame cases, random frames
// against a frame-level reference model, and hand-written multi-cycle sequences.
module tb_mac_rx_frame;

  localparam logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0;
  localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] FOREIGN   = 48'h02_00_00_00_00_01;

  typedef enum int {OUT_GOOD, OUT_BAD, OUT_SKIP} outcome_e;

  typedef struct {
    string       name;
    logic [47:0] da;
    int          len;      // bytes after SFD including FCS
    bit          bad_fcs;
    int          npre;
    int          rxer_at;  // -1: no receive error
    outcome_e    exp;
    int          exp_wr;
    int          exp_num;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_rx_frame_if bus ();

  mac_rx_frame dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  frame_q[$];
  logic [7:0]  wr_q[$];
  int          err_cnt = 0;
  int          clr_cnt = 0;
  int          txen_out = 0;
  int          fs_out = 0;
  logic [15:0] exp_drop = 16'd0;
  logic [31:0] crc_tbl[256];
  vec_t        vecs[12];

  always @(posedge clk) begin
    #1;
    if (bus.fifo_txen === 1'b1) wr_q.push_back(bus.fifo_txd);
    if (bus.err === 1'b1) err_cnt++;
    if (bus.fifo_clr === 1'b1) clr_cnt++;
    if (bus.fifo_txen === 1'b1 && bus.state_fm !== 3'd2) txen_out++;
    if (bus.fs === 1'b1 && bus.state_fm !== 3'd4) fs_out++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void init_crc_tbl();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[n] = c;
    end
  endfunction

  // Frame = DA, random bytes, then the complemented CRC sent least-significant byte first.
  function automatic void build_frame(input logic [47:0] da, input int len, input bit bad_fcs);
    logic [31:0] crc;
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(da[47-8*i -: 8]);
    for (int i = 6; i < len - 4; i++) frame_q.push_back(8'($urandom));
    crc = 32'hFFFFFFFF;
    foreach (frame_q[i]) crc = crc_tbl[(crc[7:0] ^ frame_q[i])] ^ (crc >> 8);
    fcs = ~crc;
    for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
    if (bad_fcs) frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] ^ 8'h01;
  endfunction

  function automatic outcome_e model(input logic [47:0] da, input int len, input bit bad_fcs,
                                     input int npre, input int rxer_at);
    if (npre < 6) return OUT_SKIP;
    if ((da != LOCAL_MAC && da != BCAST) || len < 64 || len > 1518 || bad_fcs || rxer_at >= 0)
      return OUT_BAD;
    return OUT_GOOD;
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(negedge clk);
    bus.gmii_rxdv = dv;
    bus.gmii_rxd  = d;
    bus.gmii_rxer = er;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input int npre, input int rxer_at);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    foreach (frame_q[i]) drive(1'b1, frame_q[i], i == rxer_at);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic fd_handshake(input string name);
    @(negedge clk) bus.fd = 1'b1;
    @(posedge clk) #1;
    check({name, ".fs_after_fd"}, 32'(bus.fs), 32'd0);
    @(negedge clk) bus.fd = 1'b0;
    @(posedge clk) #1;
    check({name, ".idle_after_fd"}, 32'(bus.state_fm), 32'd0);
  endtask

  task automatic run_frame(input vec_t v, input bit do_fd);
    int mism;
    build_frame(v.da, v.len, v.bad_fcs);
    wr_q.delete();
    err_cnt = 0;
    clr_cnt = 0;
    send_frame(v.npre, v.rxer_at);
    idle(5);
    if (v.exp == OUT_BAD) exp_drop++;
    mism = -1;
    foreach (wr_q[i]) if (mism < 0 && (i >= frame_q.size() || wr_q[i] !== frame_q[i])) mism = i;
    check({v.name, ".writes"}, 32'(wr_q.size()), 32'(v.exp_wr));
    check({v.name, ".first_bad_byte"}, 32'(mism), 32'hFFFFFFFF);
    check({v.name, ".err_pulses"}, 32'(err_cnt), (v.exp == OUT_BAD) ? 32'd1 : 32'd0);
    check({v.name, ".clr_pulses"}, 32'(clr_cnt), (v.exp == OUT_BAD) ? 32'd1 : 32'd0);
    check({v.name, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(exp_drop));
    check({v.name, ".fs"}, 32'(bus.fs), (v.exp == OUT_GOOD) ? 32'd1 : 32'd0);
    check({v.name, ".state"}, 32'(bus.state_fm), (v.exp == OUT_GOOD) ? 32'd4 : 32'd0);
    if (v.exp == OUT_GOOD) begin
      check({v.name, ".FIFO_NUM"}, 32'(bus.FIFO_NUM), 32'(v.exp_num));
      if (do_fd) fd_handshake(v.name);
    end
  endtask

  initial begin
    vec_t v;
    init_crc_tbl();
    bus.gmii_rxdv = 1'b0;
    bus.gmii_rxd  = 8'h00;
    bus.gmii_rxer = 1'b0;
    bus.fd        = 1'b0;

    vecs[0]  = '{"bcast64",    BCAST,     64,   1'b0, 7,  -1, OUT_GOOD, 60,   60};
    vecs[1]  = '{"bad_fcs",    BCAST,     64,   1'b1, 7,  -1, OUT_BAD,  60,   0};
    vecs[2]  = '{"local64",    LOCAL_MAC, 64,   1'b0, 7,  -1, OUT_GOOD, 60,   60};
    vecs[3]  = '{"foreign_da", FOREIGN,   64,   1'b0, 7,  -1, OUT_BAD,  60,   0};
    vecs[4]  = '{"len63",      BCAST,     63,   1'b0, 7,  -1, OUT_BAD,  59,   0};
    vecs[5]  = '{"len1519",    BCAST,     1519, 1'b0, 7,  -1, OUT_BAD,  1514, 0};
    vecs[6]  = '{"len1518",    LOCAL_MAC, 1518, 1'b0, 7,  -1, OUT_GOOD, 1514, 1514};
    vecs[7]  = '{"pre5",       BCAST,     64,   1'b0, 5,  -1, OUT_SKIP, 0,    0};
    vecs[8]  = '{"pre6",       BCAST,     70,   1'b0, 6,  -1, OUT_GOOD, 66,   66};
    vecs[9]  = '{"pre10",      LOCAL_MAC, 100,  1'b0, 10, -1, OUT_GOOD, 96,   96};
    vecs[10] = '{"rxer20",     BCAST,     64,   1'b0, 7,  20, OUT_BAD,  60,   0};
    vecs[11] = '{"rxer_fcs",   LOCAL_MAC, 80,   1'b0, 7,  78, OUT_BAD,  76,   0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset.state", 32'(bus.state_fm), 32'd0);
    check("reset.outputs", {bus.fifo_txen, bus.fifo_clr, bus.fs, bus.err, bus.fifo_txd},
          32'd0);
    check("reset.counts", {4'd0, bus.FIFO_NUM, bus.drop_cnt}, 32'd0);
    @(negedge clk) rst = 1'b1;
    idle(2);

    for (int i = 0; i < 12; i++) run_frame(vecs[i], 1'b1);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0:       v.da = BCAST;
        1:       v.da = LOCAL_MAC;
        default: v.da = {16'h0200, 32'($urandom)};
      endcase
      v.name    = $sformatf("rand%0d", i);
      v.len     = $urandom_range(60, 90);
      v.bad_fcs = ($urandom_range(0, 3) == 0);
      v.npre    = $urandom_range(5, 9);
      v.rxer_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, v.len - 1)) : -1;
      v.exp     = model(v.da, v.len, v.bad_fcs, v.npre, v.rxer_at);
      v.exp_wr  = (v.exp == OUT_SKIP) ? 0 : ((v.len - 4 > 1514) ? 1514 : v.len - 4);
      v.exp_num = v.len - 4;
      run_frame(v, 1'b1);
    end

    // rxdv drops mid-preamble
    wr_q.delete();
    err_cnt = 0;
    repeat (4) drive(1'b1, 8'h55, 1'b0);
    @(posedge clk) #1;
    check("pre_drop.in_pream", 32'(bus.state_fm), 32'd1);
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk) #1;
    check("pre_drop.idle", 32'(bus.state_fm), 32'd0);
    idle(3);
    check("pre_drop.writes", 32'(wr_q.size()), 32'd0);
    check("pre_drop.err", 32'(err_cnt), 32'd0);

    // Second frame arrives while the first is still held with fd low
    v = vecs[0];
    v.name = "busy_first";
    run_frame(v, 1'b0);
    build_frame(BCAST, 64, 1'b0);
    wr_q.delete();
    err_cnt = 0;
    send_frame(7, -1);
    idle(5);
    exp_drop++;
    check("busy.writes", 32'(wr_q.size()), 32'd0);
    check("busy.drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
    check("busy.FIFO_NUM", 32'(bus.FIFO_NUM), 32'd60);
    check("busy.fs", 32'(bus.fs), 32'd1);
    check("busy.state", 32'(bus.state_fm), 32'd4);
    check("busy.err", 32'(err_cnt), 32'd0);
    fd_handshake("busy");

    // Asynchronous reset in the middle of a frame
    build_frame(BCAST, 64, 1'b0);
    repeat (7) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 31; i++) drive(1'b1, frame_q[i], 1'b0);
    @(posedge clk) #2;
    rst = 1'b0;
    #1;
    check("mid_rst.state", 32'(bus.state_fm), 32'd0);
    check("mid_rst.outputs", {bus.fifo_txen, bus.fifo_clr, bus.fs, bus.err, bus.fifo_txd},
          32'd0);
    check("mid_rst.counts", {4'd0, bus.FIFO_NUM, bus.drop_cnt}, 32'd0);
    exp_drop = 16'd0;
    idle(2);
    @(negedge clk) rst = 1'b1;
    idle(2);
    v = vecs[2];
    v.name = "post_rst";
    run_frame(v, 1'b1);

    check("txen_outside_data", 32'(txen_out), 32'd0);
    check("fs_outside_ready", 32'(fs_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
